// File: rtl/mmio_accel_pkg.sv
// mmio_accel_pkg: register offsets, STATUS bit positions, run modes and FSM states for the MMIO accelerator bridge.
package mmio_accel_pkg;
    localparam int REG_CFG0     = 0;
    localparam int REG_CFG1     = 1;
    localparam int REG_CMD      = 2;
    localparam int REG_STATUS   = 3;
    localparam int REG_IRQ_MASK = 4;
    localparam int REG_PERF     = 5;
    localparam int ST_BUSY = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_EV   = 2;
    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_SA   = 2'd1;
    localparam logic [1:0] MODE_FC   = 2'd2;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction
endpackage

// File: rtl/mmio_accel_bridge_rd_pipe.sv
// mmio_rd_pipe: RD_LAT-deep read tag/data pipeline; picks register or buffer data and registers it onto rddata.
module mmio_rd_pipe #(
    parameter int REGION_W = 3,
    parameter int NUM_BUF  = 4,
    parameter int BUF_W    = 8,
    parameter int RD_LAT   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_i,
    input  logic [REGION_W-1:0]       region_i,
    input  logic [31:0]               reg_data_i,
    input  logic [NUM_BUF*BUF_W-1:0]  buf_rdata_i,
    output logic [31:0]               rddata_o
);
    logic                vld_q [RD_LAT];
    logic [REGION_W-1:0] tag_q [RD_LAT];
    logic [31:0]         dat_q [RD_LAT];
    logic [31:0]         rddata_q, rddata_d, sel;

    // Register data is captured at issue so every read sees the same latency.
    always_comb begin
        sel = '0;
        if (tag_q[RD_LAT-1] == '0)
            sel = dat_q[RD_LAT-1];
        for (int k = 0; k < NUM_BUF; k++)
            if (tag_q[RD_LAT-1] == REGION_W'(k + 1))
                sel = 32'(buf_rdata_i[k*BUF_W +: BUF_W]);
        rddata_d = vld_q[RD_LAT-1] ? sel : rddata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i] <= 1'b0;
                tag_q[i] <= '0;
                dat_q[i] <= '0;
            end
            rddata_q <= '0;
        end else begin
            vld_q[0] <= rd_i;
            tag_q[0] <= region_i;
            dat_q[0] <= reg_data_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            rddata_q <= rddata_d;
        end
    end

    assign rddata_o = rddata_q;
endmodule

// File: rtl/mmio_accel_bridge.sv
// mmio_accel_bridge: BRAM-port to accelerator bridge with buffer fan-out, config/cmd/status/irq registers and run FSM.
// Define MMIO_PERF_CNT_EN to add the saturating run-cycle counter at register offset 5.
module mmio_accel_bridge
    import mmio_accel_pkg::*;
#(
    parameter int ADDR_W   = 22,
    parameter int REGION_W = 3,
    parameter int NUM_BUF  = 4,
    parameter int OFF_W    = 17,
    parameter int BUF_W    = 8,
    parameter int RD_LAT   = 2,
    parameter int NUM_EV   = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        addr_a,
    input  logic [31:0]              wrdata_a,
    output logic [31:0]              rddata_a,
    input  logic                     en_a,
    input  logic [3:0]               we_a,
    output logic [NUM_BUF-1:0]       buf_wren_o,
    output logic [NUM_BUF-1:0]       buf_rden_o,
    output logic [OFF_W-1:0]         buf_ptr_o,
    output logic [BUF_W-1:0]         buf_wdata_o,
    input  logic [NUM_BUF*BUF_W-1:0] buf_rdata_i,
    output logic [31:0]              cfg0_o,
    output logic [31:0]              cfg1_o,
    output logic                     start_o,
    output logic [1:0]               mode_o,
    input  logic                     core_done_i,
    input  logic [NUM_EV-1:0]        ev_i,
    output logic                     irq_o
);
    localparam logic [31:0] IRQ_BITS = 32'(((64'd1 << (NUM_EV + 2)) - 64'd1) & ~64'd1);

    logic [REGION_W-1:0] region;
    logic [OFF_W-1:0]    offset;
    logic                wr, rd, is_reg, is_buf, reg_ok, reg_wr, cmd_wr, start_d, start_q, err_d, err_q, irq_d, irq_q;
    logic [31:0]         wmask, wval, st_clr, cfg0_d, cfg0_q, cfg1_d, cfg1_q, imask_d, imask_q;
    logic [31:0]         status_q, status_d, perf_rd, reg_rdata;
    logic [NUM_EV-1:0]   ev_d, ev_q;
    logic [1:0]          mode_d, mode_q;
    state_t              state_d, state_q;

    assign region = addr_a[ADDR_W-1 -: REGION_W];
    assign offset = addr_a[OFF_W+1:2];
    assign wr     = en_a & |we_a;
    assign rd     = en_a & ~|we_a;
    assign is_reg = region == '0;
    assign is_buf = !is_reg && region <= REGION_W'(NUM_BUF);
    assign reg_ok = is_reg && offset <= OFF_W'(REG_PERF);
    assign reg_wr = wr & reg_ok;
    assign wmask  = byte_mask(we_a);
    assign wval   = wrdata_a & wmask;

    always_comb begin
        buf_wren_o = '0;
        buf_rden_o = '0;
        for (int k = 0; k < NUM_BUF; k++) begin
            buf_wren_o[k] = wr & we_a[0] & (region == REGION_W'(k + 1));
            buf_rden_o[k] = rd & (region == REGION_W'(k + 1));
        end
    end
    assign buf_ptr_o   = offset;
    assign buf_wdata_o = wrdata_a[BUF_W-1:0];

    always_comb begin
        cfg0_d   = reg_wr && offset == OFF_W'(REG_CFG0) ? (cfg0_q & ~wmask) | wval : cfg0_q;
        cfg1_d   = reg_wr && offset == OFF_W'(REG_CFG1) ? (cfg1_q & ~wmask) | wval : cfg1_q;
        imask_d  = reg_wr && offset == OFF_W'(REG_IRQ_MASK) ? ((imask_q & ~wmask) | wval) & IRQ_BITS : imask_q;
        cmd_wr   = reg_wr && offset == OFF_W'(REG_CMD);
        st_clr   = reg_wr && offset == OFF_W'(REG_STATUS) ? wval : '0;
        start_d  = state_q == IDLE && cmd_wr && wrdata_a[1:0] != MODE_IDLE;
        state_d  = start_d ? RUN : (state_q == RUN && core_done_i) ? IDLE : state_q;
        mode_d   = start_d ? wrdata_a[1:0] : state_d == IDLE ? MODE_IDLE : mode_q;
        // New events and errors win over a same-cycle write-1-to-clear.
        err_d    = (en_a & ~is_buf & ~reg_ok) | (cmd_wr & state_q == RUN) | (err_q & ~st_clr[ST_ERR]);
        ev_d     = ev_i | (ev_q & ~st_clr[ST_EV +: NUM_EV]);
        status_d = 32'({ev_d, err_d, state_d == RUN});
        irq_d    = |(status_d & imask_d & IRQ_BITS);
    end
    assign status_q = 32'({ev_q, err_q, state_q == RUN});

`ifdef MMIO_PERF_CNT_EN
    logic [31:0] perf_d, perf_q;
    assign perf_d = start_d ? '0 : (state_q == RUN && perf_q != '1) ? perf_q + 32'd1 : perf_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    assign perf_rd = perf_q;
`else
    assign perf_rd = '0;
`endif

    assign reg_rdata = offset == OFF_W'(REG_CFG0)     ? cfg0_q   :
                       offset == OFF_W'(REG_CFG1)     ? cfg1_q   :
                       offset == OFF_W'(REG_STATUS)   ? status_q :
                       offset == OFF_W'(REG_IRQ_MASK) ? imask_q  :
                       offset == OFF_W'(REG_PERF)     ? perf_rd  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            mode_q  <= MODE_IDLE;
            cfg0_q  <= '0;
            cfg1_q  <= '0;
            imask_q <= '0;
            err_q   <= 1'b0;
            ev_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            mode_q  <= mode_d;
            cfg0_q  <= cfg0_d;
            cfg1_q  <= cfg1_d;
            imask_q <= imask_d;
            err_q   <= err_d;
            ev_q    <= ev_d;
            irq_q   <= irq_d;
        end
    end

    mmio_rd_pipe #(
        .REGION_W(REGION_W), .NUM_BUF(NUM_BUF), .BUF_W(BUF_W), .RD_LAT(RD_LAT)
    ) u_rd_pipe (
        .clk(clk), .rst_n(rst_n), .rd_i(rd), .region_i(region),
        .reg_data_i(reg_rdata), .buf_rdata_i(buf_rdata_i), .rddata_o(rddata_a)
    );

    assign cfg0_o  = cfg0_q;
    assign cfg1_o  = cfg1_q;
    assign start_o = start_q;
    assign mode_o  = mode_q;
    assign irq_o   = irq_q;
endmodule

// File: tb/tb_mmio_accel_bridge.sv
// tb_mmio_accel_bridge: directed checks of decode, read latency, run FSM, W1C flags, irq, error and reset behaviour.
module tb_mmio_accel_bridge;
    localparam int RD_LAT = 2;
    logic        clk = 0, rst_n = 0, en_a = 0, core_done_i = 0, start_o, irq_o;
    logic [21:0] addr_a = '0;
    logic [31:0] wrdata_a = '0, rddata_a, cfg0_o, cfg1_o, rdv;
    logic [3:0]  we_a = '0, buf_wren_o, buf_rden_o;
    logic [16:0] buf_ptr_o;
    logic [7:0]  buf_wdata_o;
    logic [31:0] buf_rdata_i = 32'h4433_2211;
    logic [1:0]  mode_o;
    logic [17:0] ev_i = '0;
    int checks = 0, errors = 0;
    logic [31:0] perf_exp;

    mmio_accel_bridge dut (
        .clk(clk), .rst_n(rst_n), .addr_a(addr_a), .wrdata_a(wrdata_a), .rddata_a(rddata_a),
        .en_a(en_a), .we_a(we_a), .buf_wren_o(buf_wren_o), .buf_rden_o(buf_rden_o),
        .buf_ptr_o(buf_ptr_o), .buf_wdata_o(buf_wdata_o), .buf_rdata_i(buf_rdata_i),
        .cfg0_o(cfg0_o), .cfg1_o(cfg1_o), .start_o(start_o), .mode_o(mode_o),
        .core_done_i(core_done_i), .ev_i(ev_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] region, input logic [16:0] off, input logic [31:0] data, input logic [3:0] we);
        en_a     = 1'b1;
        we_a     = we;
        addr_a   = (22'(region) << 19) | (22'(off) << 2);
        wrdata_a = data;
    endtask

    task automatic idle();
        en_a = 0; we_a = 0; addr_a = '0; wrdata_a = '0;
    endtask

    task automatic wr(input logic [2:0] region, input logic [16:0] off, input logic [31:0] data, input logic [3:0] we);
        drive(region, off, data, we);
        tick();
        idle();
    endtask

    task automatic rd(input logic [2:0] region, input logic [16:0] off, output logic [31:0] data);
        drive(region, off, '0, 4'h0);
        tick();
        idle();
        repeat (RD_LAT) tick();
        data = rddata_a;
    endtask

    initial begin
        tick();
        tick();
        check("reset_rddata", rddata_a, 0);
        check("reset_outs", {start_o, irq_o, mode_o}, 0);
        check("reset_cfg0", cfg0_o, 0);
        rst_n = 1;
        tick();

        // back-to-back buffer reads: data lands RD_LAT+1 cycles after each read
        drive(3'd1, 17'h0, '0, 4'h0);
        #1 check("rden_r1", 32'(buf_rden_o), 32'h1);
        tick();
        drive(3'd2, 17'h0, '0, 4'h0);
        tick();
        drive(3'd3, 17'h0, '0, 4'h0);
        check("rd_not_early", rddata_a, 0);
        tick();
        idle();
        check("rd_r1", rddata_a, 32'h11);
        tick();
        check("rd_r2", rddata_a, 32'h22);
        tick();
        check("rd_r3", rddata_a, 32'h33);

        // buffer write strobes, pointer and data in the same cycle
        drive(3'd2, 17'h1F, 32'h0000_00A5, 4'hF);
        #1 check("wren_r2", 32'(buf_wren_o), 32'h2);
        check("ptr_r2", 32'(buf_ptr_o), 32'h1F);
        check("wdata_r2", 32'(buf_wdata_o), 32'hA5);
        drive(3'd5, 17'h3, 32'h5A, 4'hF);
        #1 check("wren_unmapped", 32'(buf_wren_o), 0);
        idle();

        // per-byte register writes
        wr(3'd0, 17'd0, 32'hDEAD_BEEF, 4'hF);
        wr(3'd0, 17'd0, 32'h1122_3344, 4'b0101);
        check("cfg0_bytes", cfg0_o, 32'hDE22_BE44);
        wr(3'd0, 17'd1, 32'hCAFE_0001, 4'hF);
        rd(3'd0, 17'd1, rdv);
        check("cfg1_rd", rdv, 32'hCAFE_0001);
        rd(3'd0, 17'd3, rdv);
        check("status_clean", rdv, 0);

        // run FSM: start, rejected CMD in RUN, done
        wr(3'd0, 17'd2, 32'h1, 4'hF);
        check("start_pulse", {31'd0, start_o}, 1);
        check("mode_sa", 32'(mode_o), 1);
        tick();
        check("start_one_cycle", {31'd0, start_o}, 0);
        wr(3'd0, 17'd2, 32'h2, 4'hF);
        check("no_restart", {31'd0, start_o}, 0);
        check("mode_held", 32'(mode_o), 1);
        rd(3'd0, 17'd3, rdv);
        check("status_busy_err", rdv, 32'h3);
        rd(3'd0, 17'd2, rdv);
        check("cmd_reads0", rdv, 0);
        wr(3'd0, 17'd3, 32'h2, 4'hF);
        rd(3'd0, 17'd3, rdv);
        check("err_w1c", rdv, 32'h1);
        core_done_i = 1;
        tick();
        core_done_i = 0;
        check("mode_idle", 32'(mode_o), 0);
        rd(3'd0, 17'd3, rdv);
        check("status_done", rdv, 0);

        // sticky events and interrupt masking
        wr(3'd0, 17'd4, 32'h4, 4'hF);
        ev_i = 18'h2;
        tick();
        ev_i = 0;
        check("irq_masked", {31'd0, irq_o}, 0);
        rd(3'd0, 17'd3, rdv);
        check("ev1_sticky", rdv, 32'h8);
        ev_i = 18'h1;
        tick();
        ev_i = 0;
        check("irq_set", {31'd0, irq_o}, 1);
        wr(3'd0, 17'd3, 32'h4, 4'hF);
        check("irq_cleared", {31'd0, irq_o}, 0);
        rd(3'd0, 17'd3, rdv);
        check("ev0_cleared", rdv, 32'h8);
        drive(3'd0, 17'd3, 32'h4, 4'hF);
        ev_i = 18'h1;
        tick();
        ev_i = 0;
        idle();
        check("set_wins_irq", {31'd0, irq_o}, 1);
        rd(3'd0, 17'd3, rdv);
        check("set_wins_bit", rdv, 32'hC);

        // unmapped accesses
        rd(3'd7, 17'd0, rdv);
        check("unmapped_rd0", rdv, 0);
        rd(3'd0, 17'd3, rdv);
        check("unmapped_err", rdv, 32'hE);
        wr(3'd0, 17'd3, 32'hE, 4'hF);
        wr(3'd0, 17'd6, 32'hFFFF_FFFF, 4'hF);
        rd(3'd0, 17'd3, rdv);
        check("bad_off_err", rdv, 32'h2);
        rd(3'd0, 17'd5, rdv);
        check("perf_idle", rdv, 0);
        wr(3'd0, 17'd3, 32'h2, 4'hF);

        // perf counter over a 100-cycle run
        wr(3'd0, 17'd2, 32'h2, 4'hF);
        check("mode_fc", 32'(mode_o), 2);
        repeat (99) tick();
        core_done_i = 1;
        tick();
        core_done_i = 0;
`ifdef MMIO_PERF_CNT_EN
        perf_exp = 32'd100;
`else
        perf_exp = 32'd0;
`endif
        rd(3'd0, 17'd5, rdv);
        check("perf", rdv, perf_exp);
        rd(3'd0, 17'd3, rdv);
        check("no_err_offset5", rdv, 0);

        // asynchronous reset in the middle of a run
        wr(3'd0, 17'd2, 32'h1, 4'hF);
        tick();
        tick();
        #2 rst_n = 0;
        #1 check("rst_mode", 32'(mode_o), 0);
        check("rst_cfg", cfg0_o | cfg1_o, 0);
        check("rst_outs", {start_o, irq_o}, 0);
        check("rst_rddata", rddata_a, 0);
        tick();
        rst_n = 1;
        tick();
        check("rst_no_start", {31'd0, start_o}, 0);
        rd(3'd0, 17'd3, rdv);
        check("rst_status", rdv, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_accel_bridge.md
Name: mmio_accel_bridge

Overview:
- Parametrised memory-mapped bridge between the BRAM-controller port (AXI BRAM controller, port A) and the accelerator core.
- Decodes region/offset from the byte address and fans writes and reads out to NUM_BUF on-chip buffers.
- Holds the configuration, command, status and interrupt registers.
- Replaces level-driven start/done wiring with a run FSM, sticky write-1-to-clear (W1C) event flags and a fixed-latency read return path.

Parameters:
ADDR_W, 22, byte address width
REGION_W, 3, top address bits selecting region (region 0 = registers)
NUM_BUF, 4, buffer regions 1..NUM_BUF; must be ≤ 2^REGION_W-1
OFF_W, 17, word offset width = addr_a[OFF_W+1:2]; ADDR_W ≥ REGION_W+OFF_W+2
BUF_W, 8, buffer data width
RD_LAT, 2, buffer read latency in clk cycles (≥1)
NUM_EV, 18, core event inputs; must be ≤ 30

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
addr_a  in  ADDR_W  byte address
wrdata_a  in  32  write data
rddata_a  out  32  read data
en_a  in  1  access enable
we_a  in  4  byte write enables; 0 = read
buf_wren_o  out  NUM_BUF  one-hot buffer write strobe
buf_rden_o  out  NUM_BUF  one-hot buffer read strobe
buf_ptr_o  out  OFF_W  shared word pointer
buf_wdata_o  out  BUF_W  write data = wrdata_a[BUF_W-1:0]
buf_rdata_i  in  NUM_BUF*BUF_W  packed read data; buffer k occupies slice k
cfg0_o  out  32  CFG0 register
cfg1_o  out  32  CFG1 register
start_o  out  1  one-cycle start pulse
mode_o  out  2  1 = systolic array, 2 = fully connected; held while busy
core_done_i  in  1  run-complete pulse
ev_i  in  NUM_EV  event pulses (pool_last/act_last style)
irq_o  out  1  interrupt

Behaviour:
- Reset: all outputs, registers, pipelines and counters clear to 0; FSM goes to IDLE. Reset mid-run aborts the run, with no start and no event.
- Decode: region = addr_a[ADDR_W-1 -: REGION_W]; offset = addr_a[OFF_W+1:2].
- Write (en_a & |we_a):
  - Buffer regions: combinational buf_wren_o[region-1] = we_a[0], with buf_ptr_o and buf_wdata_o driven in the same cycle.
  - Registers: per-byte write honouring we_a.
- Read (en_a & ~|we_a):
  - Buffer regions: combinational buf_rden_o strobe.
  - A {region, offset} tag is pipelined RD_LAT stages.
  - rddata_a is registered and updates exactly RD_LAT+1 cycles after the read cycle.
  - Buffer data is zero-extended to 32 bits.
  - Register reads pass through the same delay, so latency is uniform.
  - Back-to-back reads are supported every cycle.
- Unmapped access (region > NUM_BUF, or register offset > 5):
  - Writes are dropped.
  - Reads return 0.
  - Either sets STATUS.err.
- Register map (word offset):
  - 0 CFG0: RW
  - 1 CFG1: RW
  - 2 CMD: WO, bits [1:0] = mode; reads 0
  - 3 STATUS:
    - [0] busy: RO
    - [1] err: W1C
    - [2+NUM_EV-1:2] ev sticky: W1C
  - 4 IRQ_MASK: RW, same bit layout as STATUS[31:1]
  - 5 PERF: see Optional Feature
- FSM states IDLE and RUN:
  - IDLE → RUN on a CMD write with mode ≠ 0. The next cycle, start_o = 1 for one cycle, mode_o latches and busy = 1.
  - CMD mode 0 in IDLE is ignored.
  - RUN → IDLE on core_done_i; busy clears the next cycle and mode_o returns to 0.
  - A CMD write while in RUN, including the same cycle as core_done_i, is rejected and sets err.
  - core_done_i while in IDLE is ignored.
- Sticky flags: an ev_i pulse sets its bit regardless of state. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Interrupt: irq_o registered = |(STATUS[31:1] & IRQ_MASK[31:1]); level stays high until cleared.
- Pointer/offset arithmetic is unsigned with no wrap; the offset is truncated to OFF_W.

Optional Feature:
MMIO_PERF_CNT_EN
- Defined: 32-bit counter clears on the IDLE→RUN transition, increments each RUN cycle, saturates at 0xFFFF_FFFF and holds after the run ends. Readable at offset 5.
- Undefined: no counter logic; offset 5 reads 0 and is a valid address (no err).

Decomposition:
- Package mmio_accel_pkg:
  - register offset localparams
  - STATUS bit positions
  - mode encodings (MODE_IDLE=0, MODE_SA=1, MODE_FC=2)
  - state enum (IDLE, RUN)
- Sub-module mmio_rd_pipe: RD_LAT-deep tag/data pipeline and return mux.

Test Plan:
1. Write 0x000000A5 to region 2 offset 0x1F → buf_wren_o = 4'b0010, buf_ptr_o = 0x1F, buf_wdata_o = 0xA5 in the same cycle.
2. Back-to-back reads of regions 1, 2, 3 with buf_rdata_i slices 0x11, 0x22, 0x33 → rddata_a = 0x11, 0x22, 0x33 in cycles 3, 4, 5 (RD_LAT = 2).
3. CMD = 1 → start_o pulses one cycle, busy = 1, mode_o = 1; second CMD during RUN → err = 1, no start; core_done_i → busy = 0.
4. IRQ_MASK = 0x4, pulse ev_i[1] → STATUS bit 3 = 1 but irq_o stays 0; pulse ev_i[0] → STATUS bit 2 = 1, irq_o = 1; W1C 0x4 → irq_o = 0; W1C in the same cycle as an ev_i[0] pulse → bit stays 1.
5. Read region 7 → rddata_a = 0 and err = 1; assert rst_n low mid-RUN → all outputs 0, FSM IDLE.
6. With MMIO_PERF_CNT_EN, a 100-cycle run → PERF = 100; without it, PERF reads 0.
